// File: rtl/seu_readout_pkg.sv
// Shared types and constants for the SEU counter readout engine.
// SEU_READOUT_PARITY_EN adds the PAR state to the state enum.
package seu_readout_pkg;

    localparam logic [2:0]  SEU_HDR_SYNC = 3'b101;
    localparam int unsigned SEU_HDR_LEN  = 4;

`ifdef SEU_READOUT_PARITY_EN
    typedef enum logic [1:0] {StIdle, StHdr, StData, StPar} seu_state_e;
`else
    typedef enum logic [1:0] {StIdle, StHdr, StData} seu_state_e;
`endif

    // Header bit idx (0 = first on the wire): sync pattern then the overrun flag.
    function automatic logic seu_hdr_bit(input logic [1:0] idx, input logic ovr);
        logic [3:0] hdr;
        hdr = {SEU_HDR_SYNC, ovr};
        return hdr[2'd3 - idx];
    endfunction

endpackage

// File: rtl/seu_count_readout_if.sv
// Counter-side and serial-side signals of the SEU readout engine.
// The master modport is the user, the slave modport is the engine.
interface seu_count_readout_if #(
    parameter int unsigned SEUCNTWIDTH = 8,
    parameter int unsigned NCNT        = 4
);
    logic                          readReq;
    logic [NCNT*SEUCNTWIDTH-1:0]   seuCount;
    logic                          seuCountRst;
    logic                          sdo;
    logic                          sdoValid;
    logic                          sdoFirst;
    logic                          busy;

    modport master (
        output readReq, seuCount,
        input  seuCountRst, sdo, sdoValid, sdoFirst, busy
    );

    modport slave (
        input  readReq, seuCount,
        output seuCountRst, sdo, sdoValid, sdoFirst, busy
    );
endinterface

// File: rtl/seu_readout_shifter.sv
// Parallel-load, MSB-first PISO holding the counter snapshot.
// next_msb_o is the bit that will sit at the MSB after this edge.
module seu_readout_shifter #(
    parameter int unsigned Width = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic [Width-1:0] par_i,
    output logic             next_msb_o
);
    logic [Width-1:0] data_q, data_d;

    always_comb begin
        data_d = data_q;
        if (load_i) begin
            data_d = par_i;
        end else if (shift_i) begin
            data_d = {data_q[Width-2:0], 1'b0};
        end
    end

    assign next_msb_o = data_d[Width-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end
endmodule

// File: rtl/seu_count_readout.sv
// SEU counter readout: snapshot, clear pulse, framed MSB-first serial stream.
// Define SEU_READOUT_PARITY_EN to append an even-parity bit to each frame.
module seu_count_readout
    import seu_readout_pkg::*;
#(
    parameter int unsigned SEUCNTWIDTH = 8,
    parameter int unsigned NCNT        = 4
) (
    input logic                clk,
    input logic                rst,
    seu_count_readout_if.slave bus
);
    localparam int unsigned DataW = NCNT * SEUCNTWIDTH;
    localparam int unsigned CntW  = $clog2(DataW > SEU_HDR_LEN ? DataW : SEU_HDR_LEN);
    localparam logic [CntW-1:0] HdrLast  = CntW'(SEU_HDR_LEN - 1);
    localparam logic [CntW-1:0] DataLast = CntW'(DataW - 1);

    seu_state_e      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            overrun_q, overrun_d;
    logic            ovout_q, ovout_d;
    logic            sdo_q, sdo_d;
    logic            active_q, active_d;
    logic            first_q, clr_q;
    logic            accept, last_bit, shift, next_msb;
    logic [DataW-1:0] data_par;
`ifdef SEU_READOUT_PARITY_EN
    logic            par_q, par_d;
`endif

    // Counter 0 goes to the top of the PISO so it leaves first.
    always_comb begin
        data_par = '0;
        for (int unsigned k = 0; k < NCNT; k++) begin
            data_par[DataW-1-k*SEUCNTWIDTH -: SEUCNTWIDTH] =
                bus.seuCount[k*SEUCNTWIDTH +: SEUCNTWIDTH];
        end
    end

    seu_readout_shifter #(
        .Width (DataW)
    ) u_shifter (
        .clk        (clk),
        .rst        (rst),
        .load_i     (accept),
        .shift_i    (shift),
        .par_i      (data_par),
        .next_msb_o (next_msb)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            overrun_q <= 1'b0;
            ovout_q   <= 1'b0;
            sdo_q     <= 1'b0;
            active_q  <= 1'b0;
            first_q   <= 1'b0;
            clr_q     <= 1'b0;
`ifdef SEU_READOUT_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            overrun_q <= overrun_d;
            ovout_q   <= ovout_d;
            sdo_q     <= sdo_d;
            active_q  <= active_d;
            first_q   <= accept;
            clr_q     <= accept;
`ifdef SEU_READOUT_PARITY_EN
            par_q     <= par_d;
`endif
        end
    end

    // A request on the edge that ends the last frame bit starts the next frame directly.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shift    = 1'b0;
        last_bit = 1'b0;
        unique case (state_q)
            StIdle: ;
            StHdr: begin
                if (cnt_q == HdrLast) begin
                    state_d = StData;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StData: begin
                if (cnt_q == DataLast) begin
`ifdef SEU_READOUT_PARITY_EN
                    state_d  = StPar;
`else
                    state_d  = StIdle;
                    last_bit = 1'b1;
`endif
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    shift = 1'b1;
                end
            end
`ifdef SEU_READOUT_PARITY_EN
            StPar: begin
                state_d  = StIdle;
                last_bit = 1'b1;
            end
`endif
            default: state_d = StIdle;
        endcase
        accept = bus.readReq && ((state_q == StIdle) || last_bit);
        if (accept) begin
            state_d = StHdr;
            cnt_d   = '0;
        end
    end

    always_comb begin
        overrun_d = overrun_q;
        ovout_d   = ovout_q;
        if (accept) begin
            ovout_d   = overrun_q;
            overrun_d = 1'b0;
        end else if (bus.readReq && (state_q != StIdle)) begin
            overrun_d = 1'b1;
        end

        sdo_d = 1'b0;
        unique case (state_d)
            StHdr:  sdo_d = seu_hdr_bit(cnt_d[1:0], ovout_d);
            StData: sdo_d = next_msb;
`ifdef SEU_READOUT_PARITY_EN
            StPar:  sdo_d = par_q;
`endif
            default: ;
        endcase
        active_d = (state_d != StIdle);
`ifdef SEU_READOUT_PARITY_EN
        // Running XOR of every bit already placed on sdo in this frame.
        par_d = (accept ? 1'b0 : par_q) ^ sdo_d;
`endif
    end

    assign bus.sdo         = sdo_q;
    assign bus.sdoValid    = active_q;
    assign bus.busy        = active_q;
    assign bus.sdoFirst    = first_q;
    assign bus.seuCountRst = clr_q;
endmodule

// File: tb/tb_seu_count_readout.sv
// Directed/random bench for seu_count_readout against a frame-level bit-queue model.
module tb_seu_count_readout;
    localparam int W  = 8;
    localparam int N  = 4;
    localparam int DW = W * N;
`ifdef SEU_READOUT_PARITY_EN
    localparam int EXP_L = 4 + DW + 1;
`else
    localparam int EXP_L = 4 + DW;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_err = 0;

    seu_count_readout_if #(.SEUCNTWIDTH(W), .NCNT(N)) bus_if ();

    seu_count_readout #(
        .SEUCNTWIDTH (W),
        .NCNT        (N)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected frame as a bit list: sync, overrun flag, counters 0..N-1 MSB first, parity.
    function automatic void build(input logic ov, input logic [DW-1:0] cv,
                                  output logic [63:0] v, output int n);
        bit q[$];
        bit p;
        q.push_back(1'b1);
        q.push_back(1'b0);
        q.push_back(1'b1);
        q.push_back(ov);
        for (int k = 0; k < N; k++)
            for (int b = W - 1; b >= 0; b--)
                q.push_back(cv[k*W + b]);
`ifdef SEU_READOUT_PARITY_EN
        p = 1'b0;
        foreach (q[i]) p ^= q[i];
        q.push_back(p);
`endif
        v = '0;
        foreach (q[i]) v[i] = q[i];
        n = q.size();
    endfunction

    // Called on the first bit of a frame; collects bits until sdoValid drops or a new frame starts.
    task automatic capture(input int inject_at, input bit hold, output logic [63:0] v,
                           output int n, output int rst_n, output int busy_lo);
        v = '0;
        n = 0;
        rst_n = 0;
        busy_lo = 0;
        chk("first_flag", bus_if.sdoFirst, 1);
        do begin
            if (n == inject_at) bus_if.readReq = 1'b1;
            else if (!hold) bus_if.readReq = 1'b0;
            v[n] = bus_if.sdo;
            rst_n += int'(bus_if.seuCountRst);
            if (!bus_if.busy) busy_lo++;
            n++;
            tick();
        end while (bus_if.sdoValid && !bus_if.sdoFirst && n < 60);
        if (!hold) bus_if.readReq = 1'b0;
    endtask

    task automatic req_frame(input string tag, input logic [DW-1:0] cv, input logic ov,
                             input int inject_at);
        logic [63:0] ev, gv;
        int en, gn, rn, bl;
        bus_if.seuCount = cv;
        bus_if.readReq  = 1'b1;
        tick();
        bus_if.readReq  = 1'b0;
        bus_if.seuCount = $urandom();
        chk({tag, "_clr0"}, bus_if.seuCountRst, 1);
        chk({tag, "_busy0"}, bus_if.busy, 1);
        chk({tag, "_sdo0"}, bus_if.sdo, 1);
        capture(inject_at, 1'b0, gv, gn, rn, bl);
        build(ov, cv, ev, en);
        chk({tag, "_len"}, gn, en);
        chk({tag, "_bits"}, gv, ev);
        chk({tag, "_clrcnt"}, rn, 1);
        chk({tag, "_busygap"}, bl, 0);
        chk({tag, "_valid_end"}, bus_if.sdoValid, 0);
        chk({tag, "_busy_end"}, bus_if.busy, 0);
    endtask

    initial begin
        logic [63:0] ev, gv;
        logic [DW-1:0] cv;
        int en, gn, rn, bl;

        bus_if.readReq  = 1'b0;
        bus_if.seuCount = '0;
        #2;
        chk("rst_valid", bus_if.sdoValid, 0);
        chk("rst_busy", bus_if.busy, 0);
        chk("rst_sdo", bus_if.sdo, 0);
        chk("rst_clr", bus_if.seuCountRst, 0);
        chk("rst_first", bus_if.sdoFirst, 0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Counter 3..0 = 03, 00, FF, 5A.
        req_frame("base", 32'h0300_FF5A, 1'b0, -1);
        chk("base_len_const", gn, gn);
        tick();

        req_frame("ovr_src", $urandom(), 1'b0, 5);
        tick();
        req_frame("ovr_hdr", $urandom(), 1'b1, -1);
        req_frame("ovr_clr", $urandom(), 1'b0, -1);

        // readReq held high: back-to-back frames, overrun set on all but the first.
        cv = $urandom();
        bus_if.seuCount = cv;
        bus_if.readReq  = 1'b1;
        tick();
        for (int f = 0; f < 3; f++) begin
            capture(-1, f < 2, gv, gn, rn, bl);
            build(f == 0 ? 1'b0 : 1'b1, cv, ev, en);
            chk("held_len", gn, EXP_L);
            chk("held_bits", gv, ev);
            chk("held_clrcnt", rn, 1);
            chk("held_busygap", bl, 0);
        end
        chk("held_valid_end", bus_if.sdoValid, 0);
        tick();

        // Reset at frame bit 10 after an overrun-causing request.
        bus_if.seuCount = 32'h0300_FF5A;
        bus_if.readReq  = 1'b1;
        tick();
        for (int b = 0; b < 10; b++) begin
            bus_if.readReq = (b == 5);
            tick();
        end
        bus_if.readReq = 1'b0;
        chk("pre_rst_sdo", bus_if.sdo, 1);
        chk("pre_rst_valid", bus_if.sdoValid, 1);
        rst = 1'b1;
        #1;
        chk("async_valid", bus_if.sdoValid, 0);
        chk("async_busy", bus_if.busy, 0);
        chk("async_sdo", bus_if.sdo, 0);
        chk("async_clr", bus_if.seuCountRst, 0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        req_frame("post_rst", $urandom(), 1'b0, -1);

        // All counters 1: six ones including the header, so even parity is 0.
        req_frame("ones", 32'h0101_0101, 1'b0, -1);
        build(1'b0, 32'h0101_0101, ev, en);
        chk("ones_L", en, EXP_L);

        for (int r = 0; r < 4; r++) begin
            req_frame("rand", $urandom(), 1'b0, -1);
            repeat ($urandom_range(0, 3)) tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
